mips_commit_trace: RTL

//  Sits directly downstream of main_mips. Captures every architectural commit
//  (register-file write, data-memory write) into a FIFO with its PC.

---
 rtl/mips_commit_trace.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/mips_commit_trace.sv
// mips_commit_trace: commit-log FIFO that sits behind main_mips.
// Each register-file write and each data-memory write is captured with its PC
// into a show-ahead FIFO. The FIFO drains over a valid/ready stream.
// Records that find no room are counted in a saturating drop counter, and
// they set a sticky overflow flag.
// Optional feature macro: TRACE_CYCLE_STAMP_EN adds a 32-bit capture-cycle
// stamp to every record and exposes it on rec_cycle.
module mips_commit_trace #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             trace_en,
  input  logic [31:0]      pc_in,
  input  logic             reg_we,
  input  logic [4:0]       reg_addr,
  input  logic [31:0]      reg_data,
  input  logic             mem_we,
  input  logic [31:0]      mem_addr,
  input  logic [31:0]      mem_data,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [1:0]       rec_kind,
  output logic [31:0]      rec_pc,
  output logic [31:0]      rec_addr,
  output logic [31:0]      rec_data,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             overflow
`ifdef TRACE_CYCLE_STAMP_EN
  ,
  output logic [31:0]      rec_cycle
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] KIND_REG = 2'b01;
  localparam logic [1:0] KIND_MEM = 2'b10;

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
`ifdef TRACE_CYCLE_STAMP_EN
    logic [31:0] cycle;
`endif
  } rec_t;

  rec_t             r_fifo [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [CNT_W-1:0] r_drop_cnt;
  logic             r_overflow;
`ifdef TRACE_CYCLE_STAMP_EN
  logic [31:0]      r_cycle;
`endif

  logic             w_pop;
  logic [CW-1:0]    w_free;
  logic             w_want_reg;
  logic             w_want_mem;
  logic             w_push_reg;
  logic             w_push_mem;
  logic [1:0]       w_n_push;
  logic [1:0]       w_n_drop;
  logic [AW-1:0]    w_mem_slot;
  logic [CNT_W:0]   w_drop_sum;
  logic [CNT_W-1:0] w_drop_next;
  rec_t             w_rec_reg;
  rec_t             w_rec_mem;
  rec_t             w_head;

  // Decide what is pushed and what is dropped this edge, given the space freed by a same-edge pop.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_pop       = 1'b0;
    w_free      = '0;
    w_want_reg  = 1'b0;
    w_want_mem  = 1'b0;
    w_push_reg  = 1'b0;
    w_push_mem  = 1'b0;
    w_n_push    = 2'd0;
    w_n_drop    = 2'd0;
    w_mem_slot  = r_wr_ptr;
    w_drop_sum  = '0;
    w_drop_next = r_drop_cnt;
    w_rec_reg   = '0;
    w_rec_mem   = '0;

    w_pop      = (r_count != '0) && rec_ready;
    w_free     = CW'(DEPTH) - r_count + CW'(w_pop);
    w_want_reg = trace_en && reg_we;
    w_want_mem = trace_en && mem_we;

    // The reg record claims space first, and the mem record takes what remains.
    w_push_reg = w_want_reg && (w_free != '0);
    w_push_mem = w_want_mem && (w_free >= (w_want_reg ? CW'(2) : CW'(1)));

    w_n_push = 2'(w_push_reg) + 2'(w_push_mem);
    w_n_drop = 2'(w_want_reg) + 2'(w_want_mem) - w_n_push;

    w_mem_slot = r_wr_ptr + AW'(w_push_reg);

    w_drop_sum  = {1'b0, r_drop_cnt} + (CNT_W + 1)'(w_n_drop);
    w_drop_next = w_drop_sum[CNT_W] ? {CNT_W{1'b1}} : w_drop_sum[CNT_W-1:0];

    w_rec_reg.kind = KIND_REG;
    w_rec_reg.pc   = pc_in;
    w_rec_reg.addr = {27'b0, reg_addr};
    w_rec_reg.data = reg_data;
    w_rec_mem.kind = KIND_MEM;
    w_rec_mem.pc   = pc_in;
    w_rec_mem.addr = mem_addr;
    w_rec_mem.data = mem_data;
`ifdef TRACE_CYCLE_STAMP_EN
    w_rec_reg.cycle = r_cycle;
    w_rec_mem.cycle = r_cycle;
`endif
  end

  // Pointer, occupancy, drop-accounting and cycle-counter state, with a synchronous active-low clear.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_drop_cnt <= '0;
      r_overflow <= 1'b0;
`ifdef TRACE_CYCLE_STAMP_EN
      r_cycle    <= '0;
`endif
    end else begin
      r_wr_ptr   <= r_wr_ptr + AW'(w_n_push);
      r_rd_ptr   <= r_rd_ptr + AW'(w_pop);
      r_count    <= r_count + CW'(w_n_push) - CW'(w_pop);
      r_drop_cnt <= w_drop_next;
      if (w_n_drop != 2'd0) begin
        r_overflow <= 1'b1;
      end
`ifdef TRACE_CYCLE_STAMP_EN
      r_cycle    <= r_cycle + 32'd1;
`endif
    end
  end

  // Record storage writes: the reg record goes to the tail slot, and the mem record goes to the slot after it.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; stale entries are never visible because the outputs are gated by occupancy.
    if (reset) begin
      if (w_push_reg) begin
        r_fifo[r_wr_ptr] <= w_rec_reg;
      end
      if (w_push_mem) begin
        r_fifo[w_mem_slot] <= w_rec_mem;
      end
    end
  end

  // Show-ahead head: all outputs come from state only, and they read zero whenever the FIFO is empty.
  always_comb begin
    w_head    = r_fifo[r_rd_ptr];
    rec_valid = (r_count != '0);
    rec_kind  = rec_valid ? w_head.kind : 2'b00;
    rec_pc    = rec_valid ? w_head.pc   : 32'd0;
    rec_addr  = rec_valid ? w_head.addr : 32'd0;
    rec_data  = rec_valid ? w_head.data : 32'd0;
    drop_cnt  = r_drop_cnt;
    overflow  = r_overflow;
`ifdef TRACE_CYCLE_STAMP_EN
    rec_cycle = rec_valid ? w_head.cycle : 32'd0;
`endif
  end

endmodule
